// File: rtl/hop_chain_driver.sv
// hop_chain_driver: drives staged resets and a start pulse into a hop chain,
// then times the arrival of the chain output and keeps pass/fail statistics.
// Optional feature macro: HOP_DRV_AUTO_RESEQ_EN (re-run the reset release
// sequence after any failed launch).
module hop_chain_driver #(
  parameter int RELEASE_GAP = 4,
  parameter int EXP_LAT     = 5,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clock0,
  input  logic             rst0,
  input  logic             go,
  input  logic             ff5_in,
  output logic [3:0]       hop_rst,
  output logic             start,
  output logic             busy,
  output logic [4:0]       lat,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err
);

  typedef enum logic [2:0] {
    S_HOLD, S_RELEASE, S_SETTLE, S_IDLE, S_LAUNCH, S_WAIT, S_DRAIN
  } state_t;

  localparam logic [4:0] GAP_TC    = 5'(RELEASE_GAP - 1);
  localparam logic [4:0] SETTLE_TC = 5'(EXP_LAT - 1);
  localparam logic [4:0] TO_TC     = 5'(TIMEOUT);
  localparam logic [4:0] EXP_V     = 5'(EXP_LAT);
  localparam logic [4:0] MISS_LAT  = 5'(TIMEOUT + 1);

  state_t     r_state, w_next;
  // One counter serves as release gap, settle and latency timer; the states
  // using it never overlap.
  logic [4:0] r_cnt;
  logic       r_early;   // early-fault already counted for this settle window
  logic       w_pass, w_fail, w_lat_ld;
  logic [4:0] w_lat_val;
`ifdef HOP_DRV_AUTO_RESEQ_EN
  logic       r_refail;  // last launch failed: re-sequence resets after drain
`endif

  // State register
  always_ff @(posedge clock0 or posedge rst0) begin
    if (rst0) r_state <= S_HOLD;
    else      r_state <= w_next;
  end

  // Next-state and per-launch verdict
  always_comb begin
    w_next    = r_state;
    w_pass    = 1'b0;
    w_fail    = 1'b0;
    w_lat_ld  = 1'b0;
    w_lat_val = '0;
    case (r_state)
      S_HOLD:    w_next = S_RELEASE;
      S_RELEASE: if (r_cnt == GAP_TC && hop_rst == 4'b1000) w_next = S_SETTLE;
      S_SETTLE: begin
        if (ff5_in) w_fail = !r_early;
        else if (r_cnt == SETTLE_TC) w_next = S_IDLE;
      end
      S_IDLE:    if (go) w_next = S_LAUNCH;
      S_LAUNCH:  w_next = S_WAIT;
      S_WAIT: begin
        if (ff5_in) begin
          w_lat_ld  = 1'b1;
          w_lat_val = r_cnt + 5'd1;
          w_pass    = (w_lat_val == EXP_V);
          w_fail    = !w_pass;
          w_next    = S_DRAIN;
        end else if (r_cnt == TO_TC) begin
          w_lat_ld  = 1'b1;
          w_lat_val = MISS_LAT;
          w_fail    = 1'b1;
          w_next    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!ff5_in) begin
`ifdef HOP_DRV_AUTO_RESEQ_EN
          w_next = r_refail ? S_HOLD : S_IDLE;
`else
          w_next = S_IDLE;
`endif
        end
      end
      default:   w_next = S_HOLD;
    endcase
  end

  // Registered outputs, timer and statistics
  always_ff @(posedge clock0 or posedge rst0) begin
    if (rst0) begin
      hop_rst  <= 4'b1111;
      start    <= 1'b0;
      busy     <= 1'b1;
      lat      <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      r_cnt    <= '0;
      r_early  <= 1'b0;
`ifdef HOP_DRV_AUTO_RESEQ_EN
      r_refail <= 1'b0;
`endif
    end else begin
      start <= (w_next == S_LAUNCH);
      busy  <= (w_next != S_IDLE);
      case (r_state)
        S_HOLD: begin
          r_cnt   <= '0;
          r_early <= 1'b0;
        end
        S_RELEASE: begin
          if (r_cnt == GAP_TC) begin
            r_cnt   <= '0;
            hop_rst <= hop_rst & (hop_rst - 4'd1);  // drop lowest set bit
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_SETTLE: begin
          if (r_cnt != SETTLE_TC) r_cnt <= r_cnt + 5'd1;
          if (ff5_in) r_early <= 1'b1;
        end
        S_LAUNCH, S_WAIT: r_cnt <= r_cnt + 5'd1;
        default: r_cnt <= '0;
      endcase
      if (w_lat_ld) lat <= w_lat_val;
      if (w_pass && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      if (w_fail && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      if (w_fail) err <= 1'b1;
`ifdef HOP_DRV_AUTO_RESEQ_EN
      if (r_state == S_WAIT && w_fail) r_refail <= 1'b1;
      if (r_state == S_DRAIN && w_next == S_HOLD) begin
        r_refail <= 1'b0;
        hop_rst  <= 4'b1111;
      end
`endif
    end
  end

endmodule

// File: tb/tb_hop_chain_driver.sv
// Directed bench for hop_chain_driver with a behavioural hop-chain model.
module tb_hop_chain_driver;
  logic       clock0 = 1'b0;
  logic       rst0, go, ff5_in;
  logic [3:0] hop_rst;
  logic       start, busy, err;
  logic [4:0] lat;
  logic [7:0] pass_cnt, fail_cnt;
  logic [4:0] sh;
  int         mode;   // 0: output tied low, 1: 4-flop chain, 2: 5-flop chain
  int         total = 0;
  int         bad   = 0;

  hop_chain_driver dut (
    .clock0(clock0), .rst0(rst0), .go(go), .ff5_in(ff5_in),
    .hop_rst(hop_rst), .start(start), .busy(busy), .lat(lat),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err)
  );

  always #5 clock0 = ~clock0;

  always @(posedge clock0 or posedge rst0) begin
    if (rst0) sh <= '0;
    else      sh <= {sh[3:0], start};
  end
  assign ff5_in = (mode == 1) ? sh[3] : (mode == 2) ? sh[4] : 1'b0;

  task automatic step(input int n);
    repeat (n) @(posedge clock0);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, int'(busy), 0);
  endtask

  initial begin
    rst0 = 1'b1; go = 1'b0; mode = 1;
    step(2);
    // 1: reset values and staged release
    chk("rst_hop", hop_rst, 4'b1111);
    chk("rst_busy", busy, 1);
    chk("rst_start", start, 0);
    chk("rst_lat", lat, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_err", err, 0);
    rst0 = 1'b0;
    step(1);               // HOLD -> RELEASE
    chk("hold_hop", hop_rst, 4'b1111);
    step(3);
    chk("pre_rel0", hop_rst, 4'b1111);
    step(1);
    chk("rel0", hop_rst, 4'b1110);
    step(4);
    chk("rel1", hop_rst, 4'b1100);
    step(4);
    chk("rel2", hop_rst, 4'b1000);
    step(4);
    chk("rel3", hop_rst, 4'b0000);
    step(4);
    chk("settle_busy", busy, 1);
    step(1);
    chk("idle_busy", busy, 0);

    // 2: ideal chain, single launch
    go = 1'b1;
    step(1);
    go = 1'b0;
    chk("start_on", start, 1);
    chk("launch_busy", busy, 1);
    step(1);
    chk("start_off", start, 0);
    step(3);
    chk("lat_before", lat, 0);
    step(1);
    chk("ideal_lat", lat, 5);
    chk("ideal_pass", pass_cnt, 1);
    chk("ideal_fail", fail_cnt, 0);
    chk("ideal_err", err, 0);
    step(1);
    chk("ideal_idle", busy, 0);

    // 3: one extra flop in the chain
    mode = 2;
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(5);
    chk("slow_lat_pend", lat, 5);
    step(1);
    chk("slow_lat", lat, 6);
    chk("slow_fail", fail_cnt, 1);
    chk("slow_pass", pass_cnt, 1);
    chk("slow_err", err, 1);
    step(1);
`ifdef HOP_DRV_AUTO_RESEQ_EN
    chk("slow_reseq", hop_rst, 4'b1111);
`else
    chk("slow_idle", busy, 0);
    chk("slow_hop", hop_rst, 4'b0000);
`endif
    wait_idle("slow_wait_idle", 40);

    // 4: chain output stuck low -> timeout
    mode = 0;
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(16);
    chk("miss_lat_pend", lat, 6);
    step(1);
    chk("miss_lat", lat, 17);
    chk("miss_fail", fail_cnt, 2);
    step(1);
`ifdef HOP_DRV_AUTO_RESEQ_EN
    chk("miss_reseq", hop_rst, 4'b1111);
`else
    chk("miss_idle", busy, 0);
`endif
    wait_idle("miss_wait_idle", 40);

    // 5: go held high, pass counter saturates
    mode = 1;
    go = 1'b1;
    step(2100);
    go = 1'b0;
    wait_idle("sat_wait_idle", 20);
    chk("sat_pass", pass_cnt, 255);
    chk("sat_fail", fail_cnt, 2);
    chk("sat_lat", lat, 5);
    chk("sat_err", err, 1);

    // 6: reset during WAIT
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(2);
    chk("mid_busy", busy, 1);
    rst0 = 1'b1;
    #1;
    chk("mr_hop", hop_rst, 4'b1111);
    chk("mr_busy", busy, 1);
    chk("mr_start", start, 0);
    chk("mr_lat", lat, 0);
    chk("mr_pass", pass_cnt, 0);
    chk("mr_fail", fail_cnt, 0);
    chk("mr_err", err, 0);
    step(1);
    rst0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
